// File: rtl/vmem_fill_pkg.sv
// Shared constants, register map and FSM encoding for the vmem rectangle-fill engine.
// Clipping behaviour is selected by VMEM_FILL_CLIP_EN (see vmem_fill.sv).
package vmem_fill_pkg;

  localparam logic [1:0] REG_CTRL  = 2'd0;
  localparam logic [1:0] REG_P0    = 2'd1;
  localparam logic [1:0] REG_P1    = 2'd2;
  localparam logic [1:0] REG_COLOR = 2'd3;

  localparam int LCD_W = 240;
  localparam int LCD_H = 240;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  function automatic logic [7:0] clamp_x(input logic [7:0] v);
    return (v > 8'(LCD_W - 1)) ? 8'(LCD_W - 1) : v;
  endfunction

  function automatic logic [7:0] clamp_y(input logic [7:0] v);
    return (v > 8'(LCD_H - 1)) ? 8'(LCD_H - 1) : v;
  endfunction

endpackage

// File: rtl/vmem_fill_regs.sv
// Bus-visible register file for vmem_fill: corner/colour storage, registered
// readback, and start/abort pulses decoded from CTRL writes.
module vmem_fill_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic        busy,
  input  logic        done,
  output logic [31:0] rdata_o,
  output logic [15:0] p0,
  output logic [15:0] p1,
  output logic [2:0]  color,
  output logic        start,
  output logic        abort
);
  import vmem_fill_pkg::*;

  logic [1:0] sel;
  logic       unused_bits;

  assign sel         = addr_i[3:2];
  assign unused_bits = ^{addr_i[1:0], wdata_i[31:16]};

  // Start is dropped while busy so a running fill cannot be restarted mid-way.
  assign start = we_i && (sel == REG_CTRL) && wdata_i[0] && !busy;
  assign abort = we_i && (sel == REG_CTRL) && wdata_i[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0    <= '0;
      p1    <= '0;
      color <= '0;
    end else if (we_i && !busy) begin
      case (sel)
        REG_P0:    p0    <= wdata_i[15:0];
        REG_P1:    p1    <= wdata_i[15:0];
        REG_COLOR: color <= wdata_i[2:0];
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_o <= '0;
    end else begin
      case (sel)
        REG_CTRL:  rdata_o <= {30'b0, done, busy};
        REG_P0:    rdata_o <= {16'b0, p0};
        REG_P1:    rdata_o <= {16'b0, p1};
        default:   rdata_o <= {29'b0, color};
      endcase
    end
  end

endmodule

// File: rtl/vmem_fill.sv
// Rectangle-fill engine: emits one vmem pixel write per unstalled cycle, row-major.
// Define VMEM_FILL_CLIP_EN to clamp corners to the visible 240x240 area.
module vmem_fill (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        we_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  input  logic        cpu_vmem_we_i,
  output logic        vmem_we_o,
  output logic [15:0] vmem_addr_o,
  output logic [2:0]  vmem_wdata_o,
  output logic        busy_o
);
  import vmem_fill_pkg::*;

  state_t      state_q, state_d;
  logic [15:0] p0, p1;
  logic [2:0]  color;
  logic        start, abort;
  logic        done_q;
  logic [7:0]  x_q, y_q, x0_q, x1_q, y1_q;
  logic [2:0]  color_q;
  logic [7:0]  ld_x0, ld_y0, ld_x1, ld_y1;
  logic        empty, row_end, last_px, step, run_valid;

  vmem_fill_regs u_regs (
    .clk     (clk_i),
    .rst     (rst_i),
    .we_i    (we_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .busy    (busy_o),
    .done    (done_q),
    .rdata_o (rdata_o),
    .p0      (p0),
    .p1      (p1),
    .color   (color),
    .start   (start),
    .abort   (abort)
  );

`ifdef VMEM_FILL_CLIP_EN
  assign ld_x0 = clamp_x(p0[7:0]);
  assign ld_y0 = clamp_y(p0[15:8]);
  assign ld_x1 = clamp_x(p1[7:0]);
  assign ld_y1 = clamp_y(p1[15:8]);
`else
  assign ld_x0 = p0[7:0];
  assign ld_y0 = p0[15:8];
  assign ld_x1 = p1[7:0];
  assign ld_y1 = p1[15:8];
`endif

  assign empty   = (ld_x0 > ld_x1) || (ld_y0 > ld_y1);
  assign row_end = (x_q == x1_q);
  assign last_px = row_end && (y_q == y1_q);
  assign step    = (state_q == S_RUN) && !cpu_vmem_we_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_LOAD;
      S_LOAD: state_d = (abort || empty) ? S_IDLE : S_RUN;
      S_RUN: begin
        if (abort)                state_d = S_IDLE;
        else if (step && last_px) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The only combinational output path: a CPU store steals the port this cycle.
  always_comb begin
    busy_o       = (state_q != S_IDLE);
    run_valid    = (state_q == S_RUN);
    vmem_we_o    = run_valid && !cpu_vmem_we_i;
    vmem_addr_o  = {y_q, x_q};
    vmem_wdata_o = color_q;
  end

  // Counters only advance on unstalled RUN cycles, so stalls never drop or repeat a pixel.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q     <= '0;
      y_q     <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      color_q <= '0;
    end else if (state_q == S_LOAD) begin
      x_q     <= ld_x0;
      y_q     <= ld_y0;
      x0_q    <= ld_x0;
      x1_q    <= ld_x1;
      y1_q    <= ld_y1;
      color_q <= color;
    end else if (step) begin
      if (row_end) begin
        x_q <= x0_q;
        y_q <= y_q + 8'd1;
      end else begin
        x_q <= x_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done_q <= 1'b0;
    end else if ((state_q == S_IDLE) && start) begin
      done_q <= 1'b0;
    end else if ((state_q == S_LOAD) && !abort && empty) begin
      done_q <= 1'b1;
    end else if (step && !abort && last_px) begin
      done_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vmem_fill.sv
// Directed self-checking bench for vmem_fill; inputs change on the falling edge
// and pixel writes are logged just after it, once cpu_vmem_we_i has settled.
module tb_vmem_fill;

  logic        clk;
  logic        rst;
  logic        we_i;
  logic [3:0]  addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        cpu_vmem_we_i;
  logic        vmem_we_o;
  logic [15:0] vmem_addr_o;
  logic [2:0]  vmem_wdata_o;
  logic        busy_o;

  int checks;
  int errors;
  logic [15:0] addr_log[$];
  logic [2:0]  data_log[$];

  vmem_fill dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .we_i          (we_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .rdata_o       (rdata_o),
    .cpu_vmem_we_i (cpu_vmem_we_i),
    .vmem_we_o     (vmem_we_o),
    .vmem_addr_o   (vmem_addr_o),
    .vmem_wdata_o  (vmem_wdata_o),
    .busy_o        (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    #1;
    if (vmem_we_o === 1'b1) begin
      addr_log.push_back(vmem_addr_o);
      data_log.push_back(vmem_wdata_o);
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    we_i    = 1'b1;
    addr_i  = a;
    wdata_i = d;
    @(negedge clk);
    we_i    = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    we_i   = 1'b0;
    addr_i = a;
    @(negedge clk);
    d = rdata_o;
  endtask

  task automatic wait_idle(input int max_cycles, output int cycles);
    cycles = 0;
    while (busy_o && cycles < max_cycles) begin
      cycles++;
      @(negedge clk);
    end
    check_output("idle_timeout", {31'b0, busy_o}, 32'h0);
  endtask

  task automatic clear_log();
    addr_log.delete();
    data_log.delete();
  endtask

  initial begin
    logic [31:0] rd;
    int          cyc;
    int          total;
    logic [15:0] exp4[4];

    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    we_i          = 1'b0;
    addr_i        = 4'h0;
    wdata_i       = 32'h0;
    cpu_vmem_we_i = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_output("rst_we",    {31'b0, vmem_we_o}, 32'h0);
    check_output("rst_busy",  {31'b0, busy_o},    32'h0);
    check_output("rst_addr",  {16'b0, vmem_addr_o}, 32'h0);
    check_output("rst_wdata", {29'b0, vmem_wdata_o}, 32'h0);
    check_output("rst_rdata", rdata_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    bus_read(4'h0, rd);
    check_output("rst_ctrl", rd, 32'h0);
    bus_read(4'h8, rd);
    check_output("rst_p1", rd, 32'h0);

    // 2x2 fill at origin
    bus_write(4'h4, 32'h0000_0000);
    bus_write(4'h8, 32'h0000_0101);
    bus_write(4'hC, 32'h0000_0005);
    bus_read(4'h8, rd);
    check_output("t1_p1_rb", rd, 32'h0101);
    bus_read(4'hC, rd);
    check_output("t1_col_rb", rd, 32'h5);
    clear_log();
    bus_write(4'h0, 32'h1);
    check_output("t1_busy_load", {31'b0, busy_o}, 32'h1);
    check_output("t1_we_load", {31'b0, vmem_we_o}, 32'h0);
    wait_idle(50, cyc);
    check_output("t1_busy_cycles", cyc, 32'd5);
    check_output("t1_count", addr_log.size(), 32'd4);
    exp4 = '{16'h0000, 16'h0001, 16'h0100, 16'h0101};
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      check_output($sformatf("t1_addr%0d", i), {16'b0, addr_log[i]}, {16'b0, exp4[i]});
      check_output($sformatf("t1_data%0d", i), {29'b0, data_log[i]}, 32'h5);
    end
    bus_read(4'h0, rd);
    check_output("t1_ctrl_done", rd, 32'h2);

    // Full screen, with ignored register write and start while busy
    bus_write(4'h8, 32'h0000_EFEF);
    clear_log();
    bus_write(4'h0, 32'h1);
    bus_write(4'h8, 32'h0000_1234);
    bus_write(4'h0, 32'h1);
    wait_idle(60000, cyc);
    check_output("t2_count", addr_log.size(), 32'd57600);
    if (addr_log.size() > 0) begin
      check_output("t2_first", {16'b0, addr_log[0]}, 32'h0000);
      check_output("t2_last", {16'b0, addr_log[addr_log.size()-1]}, 32'hEFEF);
    end
    bus_read(4'h0, rd);
    check_output("t2_ctrl", rd, 32'h2);
    bus_read(4'h8, rd);
    check_output("t2_p1_kept", rd, 32'hEFEF);

    // Inverted corners: no writes, done two cycles after the start write
    bus_write(4'h4, 32'h0000_0505);
    bus_write(4'h8, 32'h0000_0303);
    clear_log();
    bus_write(4'h0, 32'h1);
    check_output("t3_busy_load", {31'b0, busy_o}, 32'h1);
    @(negedge clk);
    check_output("t3_busy_off", {31'b0, busy_o}, 32'h0);
    check_output("t3_rd_load", rdata_o, 32'h1);
    @(negedge clk);
    check_output("t3_rd_done", rdata_o, 32'h2);
    repeat (3) @(negedge clk);
    check_output("t3_count", addr_log.size(), 32'd0);

    // 1x8 row with a 3-cycle CPU stall after two pixels
    bus_write(4'h4, 32'h0000_0010);
    bus_write(4'h8, 32'h0000_0017);
    bus_write(4'hC, 32'h0000_0003);
    clear_log();
    bus_write(4'h0, 32'h1);
    total = 1;
    repeat (2) @(negedge clk);
    total += 2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cpu_vmem_we_i = 1'b1;
      #1;
      check_output($sformatf("t4_stall_we%0d", i), {31'b0, vmem_we_o}, 32'h0);
      total++;
    end
    @(negedge clk);
    cpu_vmem_we_i = 1'b0;
    wait_idle(50, cyc);
    total += cyc;
    check_output("t4_busy_cycles", total, 32'd12);
    check_output("t4_count", addr_log.size(), 32'd8);
    for (int i = 0; i < 8 && i < addr_log.size(); i++) begin
      check_output($sformatf("t4_addr%0d", i), {16'b0, addr_log[i]}, 32'h10 + i);
    end
    if (data_log.size() > 0) check_output("t4_data", {29'b0, data_log[0]}, 32'h3);

    // Abort a 16x16 fill after 10 pixels
    bus_write(4'h4, 32'h0000_1020);
    bus_write(4'h8, 32'h0000_1F2F);
    bus_write(4'hC, 32'h0000_0006);
    clear_log();
    bus_write(4'h0, 32'h1);
    repeat (9) @(negedge clk);
    bus_write(4'h0, 32'h2);
    #1;
    check_output("t5_busy", {31'b0, busy_o}, 32'h0);
    check_output("t5_we", {31'b0, vmem_we_o}, 32'h0);
    repeat (5) @(negedge clk);
    check_output("t5_count", addr_log.size(), 32'd10);
    if (addr_log.size() > 0) check_output("t5_last", {16'b0, addr_log[addr_log.size()-1]}, 32'h1029);
    bus_read(4'h0, rd);
    check_output("t5_ctrl", rd, 32'h0);
    bus_write(4'h4, 32'h0000_0303);
    bus_write(4'h8, 32'h0000_0304);
    clear_log();
    bus_write(4'h0, 32'h1);
    wait_idle(50, cyc);
    check_output("t5_restart_count", addr_log.size(), 32'd2);
    if (addr_log.size() == 2) begin
      check_output("t5_restart_a0", {16'b0, addr_log[0]}, 32'h0303);
      check_output("t5_restart_a1", {16'b0, addr_log[1]}, 32'h0304);
    end
    bus_read(4'h0, rd);
    check_output("t5_restart_ctrl", rd, 32'h2);

    // Corner at the top of the coordinate range
`ifdef VMEM_FILL_CLIP_EN
    bus_write(4'h4, 32'h0000_EEEE);
    exp4 = '{16'hEEEE, 16'hEEEF, 16'hEFEE, 16'hEFEF};
`else
    bus_write(4'h4, 32'h0000_FEFE);
    exp4 = '{16'hFEFE, 16'hFEFF, 16'hFFFE, 16'hFFFF};
`endif
    bus_write(4'h8, 32'h0000_FFFF);
    clear_log();
    bus_write(4'h0, 32'h1);
    wait_idle(50, cyc);
    check_output("t6_count", addr_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < addr_log.size(); i++) begin
      check_output($sformatf("t6_addr%0d", i), {16'b0, addr_log[i]}, {16'b0, exp4[i]});
    end

    // Reset asserted mid-fill
    bus_write(4'h4, 32'h0000_0000);
    bus_write(4'h8, 32'h0000_0F0F);
    bus_write(4'h0, 32'h1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("t7_we", {31'b0, vmem_we_o}, 32'h0);
    check_output("t7_busy", {31'b0, busy_o}, 32'h0);
    check_output("t7_addr", {16'b0, vmem_addr_o}, 32'h0);
    check_output("t7_wdata", {29'b0, vmem_wdata_o}, 32'h0);
    check_output("t7_rdata", rdata_o, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    clear_log();
    repeat (10) @(negedge clk);
    check_output("t7_no_writes", addr_log.size(), 32'd0);
    bus_read(4'h8, rd);
    check_output("t7_p1_reset", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vmem_fill.md
# vmem_fill

Memory-mapped rectangle-fill engine for the 240x240 frame buffer. The CPU programs two corners and a 3-bit colour over the data bus, then writes a start bit. The engine then emits one vmem write per cycle into the vmem write port, sitting directly upstream of vmem beside the CPU store path. This offloads clear-screen and box drawing from software loops.

## Interface
- Parameters: none. Geometry constants live in the package.
- `clk_i`  in  1  system clock; one clock domain.
- `rst_i`  in  1  reset; asynchronous, active-high.
- `we_i`  in  1  bus write strobe, already qualified by the top-level decode of `dbus_addr[27]`.
- `addr_i`  in  4  register byte offset; only bits [3:2] are used.
- `wdata_i`  in  32  bus write data.
- `rdata_o`  out  32  registered read data, 1-cycle latency; reset 0.
- `cpu_vmem_we_i`  in  1  CPU store to vmem this cycle; the CPU has priority.
- `vmem_we_o`  out  1  engine write strobe to vmem; reset 0.
- `vmem_addr_o`  out  16  pixel address `{y[7:0], x[7:0]}`; reset 0.
- `vmem_wdata_o`  out  3  pixel colour `{R,G,B}`; reset 0.
- `busy_o`  out  1  engine active; reset 0.

## Operation
- Registers (offset, field):
  - 0x0 CTRL. Write: bit0 = start, bit1 = abort. Read: `{30'b0, done, busy}`.
  - 0x4 P0 `{16'b0, y0[7:0], x0[7:0]}`.
  - 0x8 P1 `{16'b0, y1, x1}`; corners are inclusive.
  - 0xC COLOR `{29'b0, c[2:0]}`.
- All registers reset to 0. P0, P1 and COLOR read back what was written.
- Writes to P0, P1 and COLOR while busy are ignored. Start while busy is ignored.
- FSM has three states:
  - IDLE: on start, clear `done` and go to LOAD.
  - LOAD: latch the clipped corners into working bounds and set `x=x0`, `y=y0`. If `x0>x1` or `y0>y1`, set `done` and return to IDLE with zero writes. Otherwise go to RUN.
  - RUN: one pixel per unstalled cycle, row-major. `x` increments; when `x==x1`, set `x=x0` and increment `y`.
  - RUN exit: on the pixel with `x==x1 && y==y1`, set `done` and go to IDLE.
- Abort in RUN or LOAD: go to IDLE on the next edge, `done` stays 0, and no further writes are issued.
- Stall: when `cpu_vmem_we_i=1`, `vmem_we_o` is forced to 0 that cycle and the pixel counters hold. No pixel is lost or duplicated. The top level muxes the vmem port to the CPU whenever `cpu_vmem_we_i=1`.
- Arithmetic: `x` and `y` are 8-bit. Pixel count is `(x1-x0+1)*(y1-y0+1)`, at most 57600 when clipped.

## Timing
- Start write sampled at edge E. Then LOAD runs in cycle E+1 and the first `vmem_we_o=1` appears in cycle E+2.
- N pixels take N unstalled cycles. Each stalled cycle adds exactly 1 cycle.
- `busy_o` rises in the cycle after E and falls in the cycle after the last pixel. `done` rises in the same cycle `busy_o` falls.
- `vmem_addr_o` and `vmem_wdata_o` are registered. `vmem_we_o` is the registered valid ANDed with `!cpu_vmem_we_i`; this is the only combinational path.
- Read data appears on `rdata_o` one cycle after `addr_i` is presented, matching the other dbus peripherals.
- Reset asserted mid-fill: all outputs go to 0 immediately and the FSM goes to IDLE. After release, no writes occur until a new start.

## Configuration
- `VMEM_FILL_CLIP_EN` defined:
  - In LOAD, any coordinate greater than 239 is clamped to 239.
  - The engine never addresses outside the visible 240x240 area.
- `VMEM_FILL_CLIP_EN` undefined:
  - Raw 8-bit coordinates up to 255 are used unchanged.
  - Writes beyond 239 land in vmem locations that are never displayed.

## Structure
- Package `vmem_fill_pkg` holds:
  - register offsets `REG_CTRL`, `REG_P0`, `REG_P1`, `REG_COLOR`;
  - the FSM state encoding `S_IDLE`, `S_LOAD`, `S_RUN`;
  - `LCD_W=240` and `LCD_H=240`.
- One sub-module, `vmem_fill_regs`, provides:
  - the register file and readback mux;
  - start/abort pulse generation;
  - the write-ignore-while-busy rule.
- The FSM and counters live in `vmem_fill`.

## Test plan
- P0=0x0000, P1=0x0101, colour 5, start → exactly 4 writes at addresses 0x0000, 0x0001, 0x0100, 0x0101, all with data 5. `busy_o` is high for 5 cycles, then `done=1`.
- Full screen, P0=0, P1=0xEFEF → 57600 writes; the last address is 0xEFEF and CTRL reads 0x2.
- Inverted corners, P0=0x0505, P1=0x0303 → zero writes; `done` is set 2 cycles after the start write.
- Hold `cpu_vmem_we_i` high for 3 cycles mid-row during a 1x8 fill → `vmem_we_o` is low on exactly those 3 cycles, 8 writes in total, and the address sequence is unbroken.
- Abort after 10 pixels of a 16x16 fill → no writes from the next cycle on, `busy=0`, `done=0`. A new start still works.
- With `VMEM_FILL_CLIP_EN` defined, P1=0xFFFF and P0=0xEEEE → 4 writes, with addresses limited to 0xEEEE..0xEFEF.
